// File: rtl/tnn_pkg.sv
// rtl/tnn_pkg.sv - shared state encoding and default parameters for the TNN column
package tnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LEARN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_INPUTS  = 16;
  localparam int DEF_NUM_NEURONS = 8;
  localparam int DEF_WBITS       = 3;
  localparam int DEF_TBITS       = 3;
  localparam int DEF_THRESHOLD   = 24;
  localparam int DEF_W_INIT      = 0;

endpackage

// File: rtl/tnn_column_if.sv
// rtl/tnn_column_if.sv - volley, weight-write and result signals of the TNN column
interface tnn_column_if
  import tnn_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int WBITS       = DEF_WBITS,
  parameter int TBITS       = DEF_TBITS
);
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_INPUTS*(TBITS+1)-1:0] spike_times;
  logic                            training;
  logic                            wr_en;
  logic [NW-1:0]                   wr_neuron;
  logic [IW-1:0]                   wr_input;
  logic [WBITS-1:0]                wr_data;
  logic                            out_valid;
  logic                            out_spike;
  logic [TBITS-1:0]                out_time;
  logic [NW-1:0]                   winner;
  logic                            busy;

  modport master (
    output in_valid, spike_times, training, wr_en, wr_neuron, wr_input, wr_data,
    input  in_ready, out_valid, out_spike, out_time, winner, busy
  );

  modport slave (
    input  in_valid, spike_times, training, wr_en, wr_neuron, wr_input, wr_data,
    output in_ready, out_valid, out_spike, out_time, winner, busy
  );

endinterface

// File: rtl/tnn_neuron.sv
// rtl/tnn_neuron.sv - ramp-no-leak body potential, threshold test and fire-tick capture
module tnn_neuron #(
  parameter int NUM_INPUTS = 16,
  parameter int WBITS      = 3,
  parameter int TBITS      = 3,
  parameter int THRESHOLD  = 24,
  parameter int PWIDTH     = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        en,
  input  logic [TBITS-1:0]            t,
  input  logic [NUM_INPUTS-1:0]       active,
  input  logic [NUM_INPUTS*WBITS-1:0] weights,
  output logic                        fire_now,
  output logic [TBITS-1:0]            fire_tick
);
  logic [PWIDTH-1:0] potential;
  logic [PWIDTH-1:0] sum;
  logic [PWIDTH-1:0] next_pot;
  logic              fired;

  // PWIDTH covers a full period of every input at WMAX, so the add cannot wrap
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (active[i]) sum = sum + PWIDTH'(weights[i*WBITS +: WBITS]);
    end
    next_pot = potential + sum;
    fire_now = en && !fired && (32'(next_pot) >= 32'(THRESHOLD));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      potential <= '0;
      fired     <= 1'b0;
      fire_tick <= '0;
    end else if (clear) begin
      potential <= '0;
      fired     <= 1'b0;
      fire_tick <= '0;
    end else if (en) begin
      potential <= next_pot;
      if (fire_now) begin
        fired     <= 1'b1;
        fire_tick <= t;
      end
    end
  end

endmodule

// File: rtl/tnn_column.sv
// rtl/tnn_column.sv - temporal neural column: volley sequencing, winner-take-all and STDP
module tnn_column
  import tnn_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int WBITS       = DEF_WBITS,
  parameter int TBITS       = DEF_TBITS,
  parameter int THRESHOLD   = DEF_THRESHOLD,
  parameter int W_INIT      = DEF_W_INIT
) (
  input  logic         clk,
  input  logic         rst,
  tnn_column_if.slave  bus
);
  localparam int NW     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int TB1    = TBITS + 1;
  localparam int WMAX   = (1 << WBITS) - 1;
  localparam int P      = 1 << TBITS;
  localparam int PWIDTH = $clog2(NUM_INPUTS * WMAX * P + 1);

  state_t                        state;
  logic [TBITS-1:0]              t;
  logic [NUM_INPUTS*TB1-1:0]     st_lat;
  logic                          train_lat;
  logic                          have_win;
  logic [NW-1:0]                 win_idx;
  logic [WBITS-1:0]              w [NUM_NEURONS][NUM_INPUTS];
  logic [NUM_INPUTS*WBITS-1:0]   w_flat [NUM_NEURONS];
  logic [NUM_INPUTS-1:0]         active;
  logic [NUM_NEURONS-1:0]        fire_now;
  logic [TBITS-1:0]              fire_tick [NUM_NEURONS];
  logic                          first_fire;
  logic [NW-1:0]                 first_idx;
  logic [TBITS-1:0]              win_tick;
  logic                          accept;

  assign accept       = (state == IDLE) && bus.in_valid;
  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign win_tick     = fire_tick[win_idx];

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      active[i] = !st_lat[i*TB1 + TBITS] && (st_lat[i*TB1 +: TBITS] <= t);
    end
    for (int n = 0; n < NUM_NEURONS; n++) begin
      for (int i = 0; i < NUM_INPUTS; i++) w_flat[n][i*WBITS +: WBITS] = w[n][i];
    end
  end

  // Descending scan leaves the lowest firing index, which resolves same-tick ties
  always_comb begin
    first_fire = 1'b0;
    first_idx  = '0;
    for (int n = NUM_NEURONS - 1; n >= 0; n--) begin
      if (fire_now[n]) begin
        first_fire = 1'b1;
        first_idx  = NW'(n);
      end
    end
  end

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_neuron
    tnn_neuron #(
      .NUM_INPUTS (NUM_INPUTS),
      .WBITS      (WBITS),
      .TBITS      (TBITS),
      .THRESHOLD  (THRESHOLD),
      .PWIDTH     (PWIDTH)
    ) u_neuron (
      .clk       (clk),
      .rst       (rst),
      .clear     (accept),
      .en        (state == RUN),
      .t         (t),
      .active    (active),
      .weights   (w_flat[g]),
      .fire_now  (fire_now[g]),
      .fire_tick (fire_tick[g])
    );
  end

  function automatic logic [WBITS-1:0] stdp(input logic [WBITS-1:0] wv, input logic x,
                                            input logic y, input logic causal);
    if (x && (!y || causal)) stdp = (&wv) ? wv : wv + 1'b1;
    else if (y)              stdp = (wv == '0) ? wv : wv - 1'b1;
    else                     stdp = wv;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      t             <= '0;
      st_lat        <= '0;
      train_lat     <= 1'b0;
      have_win      <= 1'b0;
      win_idx       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_spike <= 1'b0;
      bus.out_time  <= '0;
      bus.winner    <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        for (int i = 0; i < NUM_INPUTS; i++) w[n][i] <= WBITS'(W_INIT);
      end
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wr_en) w[bus.wr_neuron][bus.wr_input] <= bus.wr_data;
          if (bus.in_valid) begin
            st_lat    <= bus.spike_times;
            train_lat <= bus.training;
            t         <= '0;
            have_win  <= 1'b0;
            win_idx   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (!have_win && first_fire) begin
            have_win <= 1'b1;
            win_idx  <= first_idx;
          end
          t <= t + 1'b1;
          if (t == '1) state <= train_lat ? LEARN : DONE;
        end
        LEARN: begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              w[n][i] <= stdp(w[n][i], !st_lat[i*TB1 + TBITS],
                              have_win && (win_idx == NW'(n)),
                              st_lat[i*TB1 +: TBITS] <= win_tick);
            end
          end
          state <= DONE;
        end
        DONE: begin
          bus.out_valid <= 1'b1;
          bus.out_spike <= have_win;
          bus.out_time  <= have_win ? win_tick : '0;
          bus.winner    <= have_win ? win_idx : '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_column.sv
// tb/tb_tnn_column.sv - scoreboard bench for tnn_column with directed volleys
module tb_tnn_column;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   results_seen = 0;

  typedef struct {
    int spike;
    int tim;
    int win;
    int lat;
    int acc;
  } exp_t;

  exp_t exp_q[$];

  tnn_column_if bus ();

  tnn_column dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      exp_t e;
      results_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_spike", int'(bus.out_spike), e.spike);
        check("out_time", int'(bus.out_time), e.tim);
        check("winner", int'(bus.winner), e.win);
        check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  function automatic logic [63:0] spikes(input logic [15:0] mask, input logic [2:0] tick);
    logic [63:0] v;
    v = {16{4'b1000}};
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) v[i*4 +: 4] = {1'b0, tick};
    end
    return v;
  endfunction

  task automatic wr(input int n, input int i, input int d);
    @(posedge clk); #1;
    bus.wr_en     = 1'b1;
    bus.wr_neuron = 3'(n);
    bus.wr_input  = 4'(i);
    bus.wr_data   = 3'(d);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic volley(input logic [63:0] st, input logic trn, input bit push,
                        input int es, input int et, input int ew, input int el);
    wait_ready();
    bus.spike_times = st;
    bus.training    = trn;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (push) exp_q.push_back('{es, et, ew, el, cyc});
  endtask

  task automatic wait_result();
    int start = results_seen;
    int n = 0;
    while (results_seen == start && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("result_arrived", int'(results_seen != start), 1);
    #1;
  endtask

  initial begin
    logic [63:0] st;
    int nz;
    int seen;
    bus.in_valid    = 1'b0;
    bus.spike_times = '1;
    bus.training    = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_neuron   = '0;
    bus.wr_input    = '0;
    bus.wr_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_spike", int'(bus.out_spike), 0);
    check("rst_out_time", int'(bus.out_time), 0);
    check("rst_winner", int'(bus.winner), 0);

    // zero weights: nothing can reach threshold
    volley(spikes(16'hFFFF, 3'd0), 1'b0, 1'b1, 0, 0, 0, 9);
    wait_result();

    for (int i = 0; i < 4; i++) wr(2, i, 7);
    volley(spikes(16'h000F, 3'd0), 1'b0, 1'b1, 1, 0, 2, 9);
    wait_result();

    wr(2, 4, 3);
    st = spikes(16'h000F, 3'd0);
    st[19:16] = 4'b0101;
    volley(st, 1'b1, 1'b1, 1, 0, 2, 10);
    wait_result();
    for (int i = 0; i < 4; i++) check("learn_w2_causal", int'(dut.w[2][i]), 7);
    check("learn_w2_4_late", int'(dut.w[2][4]), 2);
    check("learn_w2_5_silent", int'(dut.w[2][5]), 0);
    check("learn_w0_0_loser", int'(dut.w[0][0]), 1);
    check("learn_w0_6_idle", int'(dut.w[0][6]), 0);
    check("learn_w7_4_loser", int'(dut.w[7][4]), 1);

    // write on the accept edge lands; writes and in_valid during RUN are ignored
    wait_ready();
    bus.spike_times = spikes(16'h000F, 3'd0);
    bus.training    = 1'b0;
    bus.in_valid    = 1'b1;
    bus.wr_en       = 1'b1;
    bus.wr_neuron   = 3'd2;
    bus.wr_input    = 4'd0;
    bus.wr_data     = 3'd0;
    @(posedge clk); #1;
    exp_q.push_back('{1, 1, 2, 9, cyc});
    check("run_busy", int'(bus.busy), 1);
    check("run_in_ready", int'(bus.in_ready), 0);
    bus.wr_neuron = 3'd3;
    bus.wr_data   = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b0;
    wait_result();
    check("busy_write_ignored", int'(dut.w[3][0]), 1);
    check("accept_write_taken", int'(dut.w[2][0]), 0);

    // reset at t=3 of a training volley
    volley(spikes(16'h000F, 3'd0), 1'b1, 1'b0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst_in_ready", int'(bus.in_ready), 1);
    check("midrun_rst_busy", int'(bus.busy), 0);
    check("midrun_rst_out_spike", int'(bus.out_spike), 0);
    check("midrun_rst_winner", int'(bus.winner), 0);
    nz = 0;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 16; i++) if (dut.w[n][i] != 3'd0) nz++;
    end
    check("midrun_rst_weights_nonzero", nz, 0);
    seen = results_seen;
    repeat (15) @(posedge clk);
    #1;
    check("midrun_rst_no_result", results_seen, seen);

    for (int i = 0; i < 4; i++) begin
      wr(1, i, 7);
      wr(5, i, 7);
    end
    volley(spikes(16'h000F, 3'd0), 1'b0, 1'b1, 1, 0, 1, 9);
    wait_result();
    repeat (3) @(posedge clk);
    #1;
    check("hold_winner", int'(bus.winner), 1);
    check("hold_out_spike", int'(bus.out_spike), 1);
    check("hold_out_valid", int'(bus.out_valid), 0);

    // one short of threshold at t=0, crosses at t=1
    for (int i = 8; i < 11; i++) wr(4, i, 7);
    wr(4, 11, 2);
    volley(spikes(16'h0F00, 3'd0), 1'b0, 1'b1, 1, 1, 4, 9);
    wait_result();

    wr(4, 11, 3);
    volley(spikes(16'h0F00, 3'd0), 1'b0, 1'b1, 1, 0, 4, 9);
    wait_result();

    volley(spikes(16'h0F00, 3'd7), 1'b0, 1'b1, 1, 7, 4, 9);
    wait_result();

    volley(spikes(16'h0000, 3'd0), 1'b0, 1'b1, 0, 0, 0, 9);
    wait_result();

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tnn_column.md
TNN_COLUMN -- requirements
Module: tnn_column

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 16: number of synaptic inputs per volley.
REQ-002 SHALL have parameter NUM_NEURONS, default 8: number of neurons in the column.
REQ-003 SHALL have parameter WBITS, default 3: weight width; WMAX = 2^WBITS-1.
REQ-004 SHALL have parameter TBITS, default 3: spike-time width; gamma period P = 2^TBITS ticks.
REQ-005 SHALL have parameter THRESHOLD, default 24: firing threshold on body potential.
REQ-006 SHALL have parameter W_INIT, default 0: weight value loaded on reset.
REQ-007 SHALL use one clock and an asynchronous, active-high reset.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 rst  input  1  asynchronous active-high reset.
REQ-010 in_valid  input  1  volley offered.
REQ-011 in_ready  output  1  high only in IDLE.
REQ-012 spike_times  input  NUM_INPUTS x (TBITS+1)  per input: MSB=1 means no spike, low TBITS = spike tick.
REQ-013 training  input  1  sampled on volley accept; enables STDP.
REQ-014 wr_en, wr_neuron, wr_input, wr_data  input  1, clog2(NUM_NEURONS), clog2(NUM_INPUTS), WBITS  weight write port.
REQ-015 out_valid  output  1  one-cycle result pulse.
REQ-016 out_spike, out_time, winner  output  1, TBITS, clog2(NUM_NEURONS)  any neuron fired, firing tick, winning index.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, RUN, LEARN, DONE.
REQ-019 IDLE -> RUN on in_valid && in_ready; accept edge latches spike_times and training, clears all potentials and fire flags, sets tick t=0.
REQ-020 RUN lasts exactly P cycles, t = 0..P-1; after t=P-1 go LEARN if latched training=1, else DONE.
REQ-021 Each RUN cycle: input i active iff latched MSB=0 and spike tick <= t; potential[n] += sum of w[n][i] over active inputs (ramp, no leak).
REQ-022 Potential width clog2(NUM_INPUTS*WMAX*P+1); SHALL never overflow or wrap.
REQ-023 Neuron n fires at the first t where updated potential >= THRESHOLD; fire tick recorded once.
REQ-024 Winner = earliest-firing neuron; ties resolved to lowest index; once a winner exists all other neurons are inhibited (cannot become winner, treated as not fired for STDP).
REQ-025 LEARN (1 cycle), per neuron n, input i, x = input spiked, y = n is winner: x&&y&&(x_tick<=y_tick) +1; x&&y&&(x_tick>y_tick) -1; x&&!y +1; !x&&y -1; !x&&!y unchanged.
REQ-026 Weight updates saturate at 0 and WMAX.
REQ-027 DONE: out_valid=1 for exactly one cycle, then IDLE; out_valid rises P+1 cycles after the accept edge (inference) or P+2 (training).
REQ-028 out_spike/out_time/winner are registered, update only with out_valid and hold until next result; no firing gives out_spike=0, out_time=0, winner=0.
REQ-029 Weight writes take effect only in IDLE; ignored while busy; a write and volley accept on the same edge both occur and RUN uses the new weight.
REQ-030 in_valid outside IDLE is ignored; no queueing.

Reset
REQ-031 rst SHALL force IDLE, in_ready=1, busy=0, out_valid=0, out_spike=0, out_time=0, winner=0, all weights=W_INIT, potentials=0, regardless of state (including mid-RUN/LEARN).

Structure
REQ-032 Shared package tnn_pkg SHALL hold the state enum and default parameter constants.
REQ-033 Per-neuron accumulate/threshold/fire-tick logic SHALL be sub-module tnn_neuron, instantiated NUM_NEURONS times; STDP and inhibition stay in tnn_column.

Verification (defaults)
REQ-034 Reset, all weights 0, all 16 inputs spike t=0, training=0 -> out_valid 9 cycles after accept, out_spike=0, winner=0.
REQ-035 Write w[2][0..3]=7, others 0; inputs 0-3 spike t=0 -> potential 28 at t=0, out_spike=1, out_time=0, winner=2.
REQ-036 Neurons 1 and 5 given identical weights as REQ-035 -> winner=1.
REQ-037 As REQ-035 plus w[2][4]=3, input 4 spikes t=5, training=1 -> out_valid at 10 cycles; w[2][0..3]=7, w[2][4]=2, w[2][5]=0, w[0][0]=1, w[0][6]=0.
REQ-038 rst asserted at t=3 -> next cycle in_ready=1, no out_valid, all weights=W_INIT.
REQ-039 wr_en during RUN writing w[3][0]=5 -> w[3][0] unchanged after volley completes.
